// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the
// single-port memory. The arbiter takes the slave view, the environment
// (masters plus memory) takes the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req,     m1_req;
    logic [ADDR_W-1:0] m0_addr,    m1_addr;
    logic [DATA_W-1:0] m0_wr_data, m1_wr_data;
    logic              m0_wr_ena,  m1_wr_ena;
    logic              m0_gnt,     m1_gnt;
    logic              m0_done,    m1_done;
    logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ena;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  m0_req, m0_addr, m0_wr_data, m0_wr_ena,
        input  m1_req, m1_addr, m1_wr_data, m1_wr_ena,
        input  mem_rd_data,
        output m0_gnt, m0_done, m0_rd_data,
        output m1_gnt, m1_done, m1_rd_data,
        output mem_addr, mem_wr_data, mem_wr_ena
    );

    modport master (
        output m0_req, m0_addr, m0_wr_data, m0_wr_ena,
        output m1_req, m1_addr, m1_wr_data, m1_wr_ena,
        output mem_rd_data,
        input  m0_gnt, m0_done, m0_rd_data,
        input  m1_gnt, m1_done, m1_rd_data,
        input  mem_addr, mem_wr_data, mem_wr_ena
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port memory with 1-cycle
// synchronous read. Ties go to the master that did not win last time.
// Writes occupy 2 cycles (grant, access), reads 3 (grant, access, response);
// a new grant may be issued in the same cycle the previous done pulses.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                       state;
    logic                         last_winner;  // 1: m0 wins the next tie
    logic                         winner;
    logic                         lat_wr_ena;
    logic [ADDR_W-1:0]            mem_addr_q;   // doubles as the latched address
    logic [DATA_W-1:0]            mem_wr_data_q;
    logic                         mem_wr_ena_q;
    logic [1:0]                   done_q;
    logic [1:0][DATA_W-1:0]       rd_data_q;

    logic                         any_req;
    logic                         pick;         // 1: m1 wins this cycle
    logic                         idle_gnt;

    // Arbitration: lone requester wins, otherwise the non-last winner.
    always_comb begin
        any_req  = bus.m0_req | bus.m1_req;
        pick     = bus.m1_req & (~bus.m0_req | ~last_winner);
        idle_gnt = (state == S_IDLE) & ~rst & any_req;
    end

    assign bus.m0_gnt      = idle_gnt & ~pick;
    assign bus.m1_gnt      = idle_gnt &  pick;
    assign bus.m0_done     = done_q[0];
    assign bus.m1_done     = done_q[1];
    assign bus.m0_rd_data  = rd_data_q[0];
    assign bus.m1_rd_data  = rd_data_q[1];
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.mem_wr_ena  = mem_wr_ena_q;

    // Control FSM with registered memory-side and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            last_winner   <= 1'b1;
            winner        <= 1'b0;
            lat_wr_ena    <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_wr_ena_q  <= 1'b0;
            done_q        <= '0;
            rd_data_q     <= '0;
        end else begin
            mem_wr_ena_q <= 1'b0;
            done_q       <= '0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        winner        <= pick;
                        last_winner   <= pick;
                        mem_addr_q    <= pick ? bus.m1_addr    : bus.m0_addr;
                        mem_wr_data_q <= pick ? bus.m1_wr_data : bus.m0_wr_data;
                        lat_wr_ena    <= pick ? bus.m1_wr_ena  : bus.m0_wr_ena;
                        mem_wr_ena_q  <= pick ? bus.m1_wr_ena  : bus.m0_wr_ena;
                        state         <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (lat_wr_ena) begin
                        done_q[winner] <= 1'b1;
                        state          <= S_IDLE;
                    end else begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    rd_data_q[winner] <= bus.mem_rd_data;
                    done_q[winner]    <= 1'b1;
                    state             <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transactions with literal checks, plus a
// transaction-level model compared against the DUT on every cycle.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;
    bit   chk_en;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory: 256 words, write-first not needed, 1-cycle read.
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_wr_ena) mem[bus.mem_addr[7:0]] <= bus.mem_wr_data;
        bus.mem_rd_data <= mem[bus.mem_addr[7:0]];
    end

    function automatic logic [31:0] init_word(int i);
        logic [7:0] b;
        b = i[7:0];
        return (i == 16) ? 32'hDEADBEEF : {b, 8'hA5, ~b, 8'h3C};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          last = 1'b1;        // previous winner
    bit          t_valid = 1'b0;     // one transaction in flight
    bit          t_who, t_wr;
    int          t_g, t_done;
    logic [31:0] t_addr, t_data, t_rdv;
    logic [31:0] e_rd [2] = '{32'h0, 32'h0};
    logic [1:0]  e_gnt, e_done;
    bit          a_chk, a_wr, who;
    logic [31:0] a_addr, a_data;

    always @(negedge clk) begin
        e_gnt  = '0;
        e_done = '0;
        a_chk  = 1'b0;
        if (t_valid) begin
            if (cyc == t_g + 1) begin
                a_chk = 1'b1; a_wr = t_wr; a_addr = t_addr; a_data = t_data;
            end
            if (cyc == t_done) begin
                e_done[t_who] = 1'b1;
                if (!t_wr) e_rd[t_who] = t_rdv;
                t_valid = 1'b0;
            end
        end
        if (!t_valid && !rst && (bus.m0_req || bus.m1_req)) begin
            if (bus.m0_req && bus.m1_req) who = ~last;
            else                          who = bus.m1_req;
            e_gnt[who] = 1'b1;
            last    = who;
            t_valid = 1'b1;
            t_who   = who;
            t_g     = cyc;
            t_addr  = who ? bus.m1_addr    : bus.m0_addr;
            t_data  = who ? bus.m1_wr_data : bus.m0_wr_data;
            t_wr    = who ? bus.m1_wr_ena  : bus.m0_wr_ena;
            t_done  = cyc + (t_wr ? 2 : 3);
            if (t_wr) ref_mem[t_addr[7:0]] = t_data;
            else      t_rdv = ref_mem[t_addr[7:0]];
        end
        if (chk_en) begin
            chk("m_gnt",     {bus.m1_gnt, bus.m0_gnt},   e_gnt);
            chk("m_done",    {bus.m1_done, bus.m0_done}, e_done);
            chk("m_wr_ena",  bus.mem_wr_ena, a_chk && a_wr);
            chk("m_rd0",     bus.m0_rd_data, e_rd[0]);
            chk("m_rd1",     bus.m1_rd_data, e_rd[1]);
            if (a_chk) begin
                chk("m_addr", bus.mem_addr, a_addr);
                if (a_wr) chk("m_wdata", bus.mem_wr_data, a_data);
            end
        end
        if (rst) begin
            t_valid = 1'b0;
            last    = 1'b1;
            e_rd[0] = '0;
            e_rd[1] = '0;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic mid();
        @(negedge clk);
    endtask

    int gq[$];
    int alt_bad;

    initial begin
        cyc = 0; n_tests = 0; n_fail = 0; chk_en = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        bus.m0_req = 0; bus.m0_addr = 0; bus.m0_wr_data = 0; bus.m0_wr_ena = 0;
        bus.m1_req = 0; bus.m1_addr = 0; bus.m1_wr_data = 0; bus.m1_wr_ena = 0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0; chk_en = 1'b1;

        // reset state
        mid();
        chk("rst_gnt",  {bus.m1_gnt, bus.m0_gnt}, 2'b00);
        chk("rst_done", {bus.m1_done, bus.m0_done}, 2'b00);
        chk("rst_wena", bus.mem_wr_ena, 1'b0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_rd0",  bus.m0_rd_data, 32'h0);
        chk("rst_rd1",  bus.m1_rd_data, 32'h0);
        tick();

        // single m0 read of 0x10
        bus.m0_req = 1; bus.m0_addr = 32'h10; bus.m0_wr_ena = 0;
        mid(); chk("rd_gnt", bus.m0_gnt, 1'b1);
        tick(); bus.m0_req = 0;
        mid(); chk("rd_addr", bus.mem_addr, 32'h10); chk("rd_wena", bus.mem_wr_ena, 1'b0);
        tick(); tick();
        mid(); chk("rd_done", bus.m0_done, 1'b1); chk("rd_data", bus.m0_rd_data, 32'hDEADBEEF);
        tick();

        // single m1 write of 0x12345678 to 0x20
        bus.m1_req = 1; bus.m1_addr = 32'h20; bus.m1_wr_data = 32'h12345678; bus.m1_wr_ena = 1;
        mid(); chk("wr_gnt", bus.m1_gnt, 1'b1);
        tick(); bus.m1_req = 0;
        mid();
        chk("wr_wena",  bus.mem_wr_ena, 1'b1);
        chk("wr_addr",  bus.mem_addr, 32'h20);
        chk("wr_wdata", bus.mem_wr_data, 32'h12345678);
        tick();
        mid();
        chk("wr_done",  bus.m1_done, 1'b1);
        chk("wr_wena0", bus.mem_wr_ena, 1'b0);
        chk("wr_rd1",   bus.m1_rd_data, 32'h0);
        tick();

        // m1 reads back the word just written
        bus.m1_wr_ena = 0;
        bus.m1_req = 1;
        mid(); tick(); bus.m1_req = 0;
        tick(); tick();
        mid();
        chk("rb_rd1", bus.m1_rd_data, 32'h12345678);
        chk("rb_rd0", bus.m0_rd_data, 32'hDEADBEEF);
        tick();

        // m1 request arrives while m0 read is in its access cycle
        bus.m0_req = 1; bus.m0_addr = 32'h10; bus.m0_wr_ena = 0;
        mid(); tick(); bus.m0_req = 0;
        bus.m1_req = 1; bus.m1_addr = 32'h20; bus.m1_wr_ena = 0;
        mid(); chk("pend_gnt_acc", bus.m1_gnt, 1'b0);
        tick(); mid(); chk("pend_gnt_resp", bus.m1_gnt, 1'b0);
        tick(); mid(); chk("pend_gnt", bus.m1_gnt, 1'b1); chk("pend_m0done", bus.m0_done, 1'b1);
        tick(); bus.m1_req = 0;
        tick(); tick();
        mid(); chk("pend_m1done", bus.m1_done, 1'b1); chk("pend_m1rd", bus.m1_rd_data, 32'h12345678);
        tick();

        // continuous contention right after reset
        rst = 1'b1; tick(); rst = 1'b0;
        bus.m0_req = 1; bus.m0_addr = 32'h30; bus.m0_wr_data = 32'h00000A0A; bus.m0_wr_ena = 1;
        bus.m1_req = 1; bus.m1_addr = 32'h31; bus.m1_wr_data = 32'h0000B0B0; bus.m1_wr_ena = 1;
        for (int k = 0; k < 12; k++) begin
            mid();
            if (bus.m0_gnt) gq.push_back(0);
            if (bus.m1_gnt) gq.push_back(1);
            tick();
        end
        bus.m0_req = 0; bus.m1_req = 0;
        chk("cont_count", gq.size(), 6);
        if (gq.size() > 0) chk("cont_first", gq[0], 0);
        alt_bad = 0;
        for (int i = 1; i < gq.size(); i++) if (gq[i] == gq[i-1]) alt_bad++;
        chk("cont_alternate", alt_bad, 0);
        tick(); tick();

        // back-to-back m0 writes with req held
        bus.m0_req = 1; bus.m0_addr = 32'h38; bus.m0_wr_data = 32'h55; bus.m0_wr_ena = 1;
        for (int k = 0; k < 7; k++) begin
            mid();
            chk("b2b_gnt",  bus.m0_gnt,  (k % 2) == 0);
            chk("b2b_done", bus.m0_done, (k >= 2) && ((k % 2) == 0));
            tick();
        end
        bus.m0_req = 0;
        tick(); tick();

        // reset during the access cycle of an m0 write; m0 won last
        bus.m0_req = 1; bus.m0_addr = 32'h40; bus.m0_wr_data = 32'hCAFE0001; bus.m0_wr_ena = 1;
        mid(); chk("ab_gnt", bus.m0_gnt, 1'b1);
        tick(); bus.m0_req = 0; rst = 1'b1;
        tick(); rst = 1'b0;
        mid(); chk("ab_wena", bus.mem_wr_ena, 1'b0); chk("ab_done", {bus.m1_done, bus.m0_done}, 2'b00);
        tick();
        bus.m0_req = 1; bus.m0_addr = 32'h10; bus.m0_wr_ena = 0;
        bus.m1_req = 1; bus.m1_addr = 32'h20; bus.m1_wr_ena = 0;
        mid(); chk("ab_tie_m0", bus.m0_gnt, 1'b1); chk("ab_tie_m1", bus.m1_gnt, 1'b0);
        tick(); bus.m0_req = 0;
        tick(); tick();
        mid(); chk("ab_m1_next", bus.m1_gnt, 1'b1);
        tick(); bus.m1_req = 0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports m0_req / m1_req  input  1  master request, held until that master's gnt.
REQ-006 SHALL have ports m0_addr / m1_addr  input  ADDR_W  request address.
REQ-007 SHALL have ports m0_wr_data / m1_wr_data  input  DATA_W  write data.
REQ-008 SHALL have ports m0_wr_ena / m1_wr_ena  input  1  1=write, 0=read.
REQ-009 SHALL have ports m0_gnt / m1_gnt  output  1  one-cycle pulse: request accepted.
REQ-010 SHALL have ports m0_done / m1_done  output  1  one-cycle pulse: access complete.
REQ-011 SHALL have ports m0_rd_data / m1_rd_data  output  DATA_W  read result, valid with done after a read.
REQ-012 SHALL have ports mem_addr  output  ADDR_W, mem_wr_data  output  DATA_W, mem_wr_ena  output  1, mem_rd_data  input  DATA_W: single-port memory with 1-cycle synchronous read.

Function
REQ-013 SHALL implement FSM states S_IDLE, S_ACCESS, S_RESP.
REQ-014 SHALL, in S_IDLE with any request, assert exactly one gnt combinationally, latch that master's addr/wr_data/wr_ena and winner index, and move to S_ACCESS.
REQ-015 SHALL, with a single requester, grant it; with both requesting, grant the master not equal to last_winner; update last_winner on every grant.
REQ-016 SHALL, in S_ACCESS, drive mem_addr/mem_wr_data from latched values and mem_wr_ena = latched wr_ena.
REQ-017 SHALL, from S_ACCESS, go to S_IDLE on a write and to S_RESP on a read.
REQ-018 SHALL, in S_RESP, keep mem_addr at latched value, capture mem_rd_data into the winner's rd_data register, and go to S_IDLE.
REQ-019 SHALL register done: winner's done pulses in the cycle after S_ACCESS (write) or after S_RESP (read); the read's rd_data is valid in that same cycle.
REQ-020 SHALL hold each mX_rd_data until that master's next completed read; the other master's rd_data is unaffected.
REQ-021 SHALL hold mem_wr_ena at 0 in every state except S_ACCESS.
REQ-022 SHALL ignore requests outside S_IDLE; they remain pending and are arbitrated on return to S_IDLE.
REQ-023 SHALL permit a grant in the same cycle a done pulse is emitted (back-to-back: write every 2 cycles, read every 3).
REQ-024 SHALL never assert both gnt outputs, both done outputs, or gnt outside S_IDLE.

Reset
REQ-025 SHALL on rst enter S_IDLE; last_winner=1 (m0 wins first tie); gnt, done, mem_wr_ena = 0; latched registers, mem_addr, mem_wr_data, m0_rd_data, m1_rd_data = 0.
REQ-026 SHALL on rst mid-transaction abort it: no done pulse and no mem_wr_ena in the cycle following rst deassertion.

Verification
REQ-027 SHALL cover a single m0 read: addr 0x10, memory word 0xDEADBEEF -> m0_gnt cycle 0, S_ACCESS cycle 1, S_RESP cycle 2, m0_done=1 and m0_rd_data=0xDEADBEEF cycle 3.
REQ-028 SHALL cover a single m1 write: addr 0x20, data 0x12345678 -> mem_wr_ena=1 for exactly one cycle with those values, m1_done cycle 2, m1_rd_data unchanged.
REQ-029 SHALL cover continuous contention: both req held high after reset -> grants alternate m0, m1, m0, m1; no master is granted twice in a row.
REQ-030 SHALL cover back-to-back m0 writes with m0_req held high -> gnt every 2 cycles, coinciding with the prior done.
REQ-031 SHALL cover rst asserted in S_ACCESS of a write -> mem_wr_ena=0, no done pulse, next tie granted to m0.
REQ-032 SHALL cover a pending request during a busy access: m1 requests while m0 read is in S_ACCESS -> m1_gnt in the cycle m0_done pulses.
